// File: rtl/cmd_link.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_link
//  Description : Byte-to-command bridge. Assembles two UART bytes into a
//                16-bit command for dig_core and back-pressures the UART
//                until the command is cleared. Returns 8-bit responses to the
//                UART transmitter through a one-deep pending register.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_link #(
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    // UART receive side
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    // command handshake to dig_core
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    // response handshake from dig_core
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    // UART transmit side
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    // status
    output logic        to_err,
    output logic        resp_ovr
);

    localparam int                c_TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TO_MAX = c_TIMER_W'(TIMEOUT - 1);

    localparam logic [1:0] c_RX_IDLE = 2'd0;
    localparam logic [1:0] c_RX_HIGH = 2'd1;
    localparam logic [1:0] c_RX_FULL = 2'd2;

    localparam logic       c_TX_IDLE = 1'b0;
    localparam logic       c_TX_BUSY = 1'b1;

    logic [1:0]           r_rx_state, w_rx_next;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 w_cap_hi, w_cap_lo, w_timeout, w_tick, w_clr_cmd;

    logic                 r_tx_state, w_tx_next;
    logic                 r_pend_vld;
    logic [7:0]           r_pend_byte;
    logic                 w_load_new, w_load_pend, w_store_pend, w_drop, w_done;

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------

    // Receive state register
    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= c_RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // Receive next-state: a byte always beats a simultaneous timeout
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            c_RX_IDLE: if (rx_rdy) w_rx_next = c_RX_HIGH;
            c_RX_HIGH: begin
                if (rx_rdy)                  w_rx_next = c_RX_FULL;
                else if (r_timer == c_TO_MAX) w_rx_next = c_RX_IDLE;
            end
            c_RX_FULL: if (clr_cmd_rdy) w_rx_next = c_RX_IDLE;
            default:   w_rx_next = c_RX_IDLE;
        endcase
    end

    // Receive decode; gated by rst so no byte is consumed while resetting
    always_comb begin
        w_cap_hi   = !rst && (r_rx_state == c_RX_IDLE) && rx_rdy;
        w_cap_lo   = !rst && (r_rx_state == c_RX_HIGH) && rx_rdy;
        w_timeout  = (r_rx_state == c_RX_HIGH) && !rx_rdy && (r_timer == c_TO_MAX);
        w_tick     = (r_rx_state == c_RX_HIGH) && !rx_rdy && (r_timer != c_TO_MAX);
        w_clr_cmd  = (r_rx_state == c_RX_FULL) && clr_cmd_rdy;
        clr_rx_rdy = w_cap_hi || w_cap_lo;
    end

    // Command assembly, ready flag and inter-byte timer
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
            to_err  <= 1'b0;
            r_timer <= '0;
        end else begin
            to_err <= w_timeout;
            if (w_cap_hi) begin
                cmd[15:8] <= rx_data;
                r_timer   <= '0;
            end
            if (w_cap_lo) begin
                cmd[7:0] <= rx_data;
                cmd_rdy  <= 1'b1;
            end
            if (w_clr_cmd) cmd_rdy <= 1'b0;
            if (w_tick)    r_timer <= r_timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------------

    // Transmit state register
    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= c_TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    // Transmit next-state: leave BUSY only when nothing else is waiting
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            c_TX_IDLE: if (send_resp) w_tx_next = c_TX_BUSY;
            c_TX_BUSY: if (tx_done && !r_pend_vld && !send_resp) w_tx_next = c_TX_IDLE;
            default:   w_tx_next = c_TX_IDLE;
        endcase
    end

    // Transmit decode; a new byte arriving with tx_done bypasses the pending slot
    always_comb begin
        w_load_new   = send_resp && ((r_tx_state == c_TX_IDLE) ||
                                     (tx_done && !r_pend_vld));
        w_load_pend  = (r_tx_state == c_TX_BUSY) && tx_done && r_pend_vld;
        w_store_pend = (r_tx_state == c_TX_BUSY) && send_resp && !r_pend_vld && !tx_done;
        w_drop       = (r_tx_state == c_TX_BUSY) && send_resp && r_pend_vld;
        w_done       = (r_tx_state == c_TX_BUSY) && tx_done;
    end

    // Transmit datapath: byte register, pending slot, pulses and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= 8'h00;
            trmt        <= 1'b0;
            resp_sent   <= 1'b0;
            resp_ovr    <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_byte <= 8'h00;
        end else begin
            trmt      <= w_load_new || w_load_pend;
            resp_sent <= w_done;
            if (w_load_new)       tx_data <= resp;
            else if (w_load_pend) tx_data <= r_pend_byte;
            if (w_store_pend) begin
                r_pend_vld  <= 1'b1;
                r_pend_byte <= resp;
            end else if (w_load_pend) begin
                r_pend_vld <= 1'b0;
            end
            if (w_drop) resp_ovr <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_link.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_link
//  Description : Directed, table-driven bench for cmd_link. A default
//                instance covers the command/response paths; a TIMEOUT=8
//                instance covers the inter-byte timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_link;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy, clr_cmd_rdy, send_resp, tx_done;
    logic [7:0]  rx_data, resp;
    logic        clr_rx_rdy, cmd_rdy, resp_sent, trmt, to_err, resp_ovr;
    logic [15:0] cmd;
    logic [7:0]  tx_data;

    logic        rx_rdy8, clr_cmd8;
    logic [7:0]  rx_data8;
    logic        tie0 = 1'b0;
    logic [7:0]  tie8 = 8'h00;
    logic        clr_rx8, cmd_rdy8, resp_sent8, trmt8, to_err8, resp_ovr8;
    logic [15:0] cmd8;
    logic [7:0]  tx_data8;

    int n_chk = 0;
    int n_err = 0;
    int n_clr = 0, n_te = 0, n_trmt = 0, n_rs = 0, n_te8 = 0;

    always #5 clk = ~clk;

    cmd_link dut (
        .clk(clk), .rst(rst),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .to_err(to_err), .resp_ovr(resp_ovr)
    );

    cmd_link #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst),
        .rx_rdy(rx_rdy8), .rx_data(rx_data8), .clr_rx_rdy(clr_rx8),
        .cmd(cmd8), .cmd_rdy(cmd_rdy8), .clr_cmd_rdy(clr_cmd8),
        .resp(tie8), .send_resp(tie0), .resp_sent(resp_sent8),
        .tx_data(tx_data8), .trmt(trmt8), .tx_done(tie0),
        .to_err(to_err8), .resp_ovr(resp_ovr8)
    );

    // Pulse counters, sampled on the active edge
    always @(posedge clk) begin
        if (clr_rx_rdy) n_clr  <= n_clr + 1;
        if (to_err)     n_te   <= n_te + 1;
        if (trmt)       n_trmt <= n_trmt + 1;
        if (resp_sent)  n_rs   <= n_rs + 1;
        if (to_err8)    n_te8  <= n_te8 + 1;
    end

    typedef struct {
        logic        rx_rdy;
        logic [7:0]  rx_data;
        logic        clr_cmd;
        logic        send;
        logic [7:0]  resp;
        logic        tx_done;
        logic        e_clr;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_trmt;
        logic [7:0]  e_txd;
        logic        e_rs;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rx_rdy = 0; rx_data = 8'h00; clr_cmd_rdy = 0;
        send_resp = 0; resp = 8'h00; tx_done = 0;
    endtask

    int c0, t0, r0, e0, k_hit, te8_0;

    initial begin
        idle_inputs();
        rx_rdy8 = 0; rx_data8 = 8'h00; clr_cmd8 = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;

        // ---------------- reset values ----------------
        chk("rst cmd", cmd, 16'h0000);
        chk("rst cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("rst clr_rx_rdy", {15'd0, clr_rx_rdy}, 16'd0);
        chk("rst tx_data", {8'd0, tx_data}, 16'd0);
        chk("rst trmt/resp_sent/to_err/resp_ovr",
            {12'd0, trmt, resp_sent, to_err, resp_ovr}, 16'd0);

        // ---------------- vector table ----------------
        //          rx d     clr snd resp done | eclr ecmd     rdy trmt txd  rs
        tbl[0]  = '{1, 8'hA5, 0, 0, 8'h00, 0,  1, 16'hA500, 0, 0, 8'h00, 0};
        tbl[1]  = '{0, 8'h00, 0, 0, 8'h00, 0,  0, 16'hA500, 0, 0, 8'h00, 0};
        tbl[2]  = '{1, 8'h3C, 0, 0, 8'h00, 0,  1, 16'hA53C, 1, 0, 8'h00, 0};
        tbl[3]  = '{1, 8'h11, 0, 0, 8'h00, 0,  0, 16'hA53C, 1, 0, 8'h00, 0};
        tbl[4]  = '{1, 8'h11, 0, 1, 8'hA5, 0,  0, 16'hA53C, 1, 1, 8'hA5, 0};
        tbl[5]  = '{1, 8'h11, 1, 0, 8'h00, 0,  0, 16'hA53C, 0, 0, 8'hA5, 0};
        tbl[6]  = '{1, 8'h11, 0, 0, 8'h00, 0,  1, 16'h113C, 0, 0, 8'hA5, 0};
        tbl[7]  = '{0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h113C, 0, 0, 8'hA5, 1};
        tbl[8]  = '{1, 8'h22, 1, 0, 8'h00, 1,  1, 16'h1122, 1, 0, 8'hA5, 0};
        tbl[9]  = '{0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h1122, 1, 0, 8'hA5, 0};
        tbl[10] = '{0, 8'h00, 1, 0, 8'h00, 0,  0, 16'h1122, 0, 0, 8'hA5, 0};

        for (int i = 0; i < 11; i++) begin
            rx_rdy = tbl[i].rx_rdy;   rx_data = tbl[i].rx_data;
            clr_cmd_rdy = tbl[i].clr_cmd;
            send_resp = tbl[i].send; resp = tbl[i].resp;
            tx_done = tbl[i].tx_done;
            #1;
            chk($sformatf("v%0d clr_rx_rdy", i), {15'd0, clr_rx_rdy}, {15'd0, tbl[i].e_clr});
            @(posedge clk); #1;
            chk($sformatf("v%0d cmd", i), cmd, tbl[i].e_cmd);
            chk($sformatf("v%0d cmd_rdy", i), {15'd0, cmd_rdy}, {15'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d trmt", i), {15'd0, trmt}, {15'd0, tbl[i].e_trmt});
            chk($sformatf("v%0d tx_data", i), {8'd0, tx_data}, {8'd0, tbl[i].e_txd});
            chk($sformatf("v%0d resp_sent", i), {15'd0, resp_sent}, {15'd0, tbl[i].e_rs});
            chk($sformatf("v%0d to_err/ovr", i), {14'd0, to_err, resp_ovr}, 16'd0);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        // ---------------- 10-cycle gap, then hold with pending byte ----------------
        c0 = n_clr; e0 = n_te;
        rx_rdy = 1; rx_data = 8'hA5;
        @(negedge clk); rx_rdy = 0;
        repeat (10) @(negedge clk);
        rx_rdy = 1; rx_data = 8'h3C;
        @(negedge clk); rx_rdy = 0;
        chk("gap cmd", cmd, 16'hA53C);
        chk("gap cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("gap clr pulses", 16'(n_clr - c0), 16'd2);
        chk("gap to_err", 16'(n_te - e0), 16'd0);
        rx_rdy = 1; rx_data = 8'h11;
        repeat (20) @(negedge clk);
        chk("hold clr pulses", 16'(n_clr - c0), 16'd2);
        chk("hold cmd", cmd, 16'hA53C);
        clr_cmd_rdy = 1;
        @(negedge clk); clr_cmd_rdy = 0;
        chk("after clear cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("after clear clr_rx_rdy", {15'd0, clr_rx_rdy}, 16'd1);
        @(negedge clk); rx_rdy = 0;
        chk("pending byte cmd", cmd, 16'h113C);
        chk("pending byte clr pulses", 16'(n_clr - c0), 16'd3);

        // ---------------- timeout (TIMEOUT=8) ----------------
        te8_0 = n_te8; k_hit = 0;
        rx_rdy8 = 1; rx_data8 = 8'h7E;
        @(posedge clk); #1 rx_rdy8 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (to_err8 && k_hit == 0) k_hit = k;
        end
        chk("timeout latency", 16'(k_hit), 16'd8);
        chk("timeout pulse count", 16'(n_te8 - te8_0), 16'd1);
        chk("timeout cmd kept", cmd8, 16'h7E00);
        @(negedge clk);
        rx_rdy8 = 1; rx_data8 = 8'h01;
        @(negedge clk); rx_data8 = 8'h02;
        @(negedge clk); rx_rdy8 = 0;
        chk("post-timeout cmd", cmd8, 16'h0102);
        chk("post-timeout cmd_rdy", {15'd0, cmd_rdy8}, 16'd1);

        // byte arriving exactly when timer is at TIMEOUT-1 wins
        clr_cmd8 = 1;
        @(negedge clk); clr_cmd8 = 0;
        te8_0 = n_te8;
        rx_rdy8 = 1; rx_data8 = 8'hAA;
        @(posedge clk); #1 rx_rdy8 = 0;
        repeat (7) @(posedge clk);
        #1 rx_rdy8 = 1; rx_data8 = 8'hBB;
        @(posedge clk); #1 rx_rdy8 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("boundary cmd", cmd8, 16'hAABB);
        chk("boundary cmd_rdy", {15'd0, cmd_rdy8}, 16'd1);
        chk("boundary no to_err", 16'(n_te8 - te8_0), 16'd0);
        @(negedge clk);

        // ---------------- response overflow ----------------
        t0 = n_trmt; r0 = n_rs;
        send_resp = 1; resp = 8'h00;
        @(negedge clk); resp = 8'h01;
        chk("ovr first trmt", {15'd0, trmt}, 16'd1);
        chk("ovr first tx_data", {8'd0, tx_data}, 16'h0000);
        @(negedge clk); resp = 8'h02;
        @(negedge clk); resp = 8'h03;
        @(negedge clk); send_resp = 0;
        chk("ovr flag", {15'd0, resp_ovr}, 16'd1);
        chk("ovr tx_data held", {8'd0, tx_data}, 16'h0000);
        tx_done = 1;
        @(negedge clk); tx_done = 0;
        chk("ovr pend trmt", {15'd0, trmt}, 16'd1);
        chk("ovr pend tx_data", {8'd0, tx_data}, 16'h0001);
        chk("ovr first resp_sent", {15'd0, resp_sent}, 16'd1);
        repeat (3) @(negedge clk);
        tx_done = 1;
        @(negedge clk); tx_done = 0;
        chk("ovr second resp_sent", {15'd0, resp_sent}, 16'd1);
        chk("ovr no third trmt", {15'd0, trmt}, 16'd0);
        repeat (2) @(negedge clk);
        tx_done = 1;
        @(negedge clk); tx_done = 0;
        chk("idle tx_done ignored", {15'd0, resp_sent}, 16'd0);
        @(negedge clk);
        chk("ovr trmt count", 16'(n_trmt - t0), 16'd2);
        chk("ovr resp_sent count", 16'(n_rs - r0), 16'd2);

        // ---------------- reset mid-operation ----------------
        rx_rdy = 1; rx_data = 8'h5A;
        @(negedge clk); rx_rdy = 0;
        send_resp = 1; resp = 8'h44;
        @(negedge clk); resp = 8'h55;
        @(negedge clk); send_resp = 0;
        t0 = n_trmt; r0 = n_rs;
        rst = 1; tx_done = 1; rx_rdy = 1; rx_data = 8'h99;
        #1;
        chk("rst clr_rx_rdy gated", {15'd0, clr_rx_rdy}, 16'd0);
        @(negedge clk);
        rx_rdy = 0; tx_done = 0;
        chk("mid-rst cmd", cmd, 16'h0000);
        chk("mid-rst cmd8", cmd8, 16'h0000);
        chk("mid-rst flags",
            {10'd0, cmd_rdy, clr_rx_rdy, trmt, resp_sent, to_err, resp_ovr}, 16'd0);
        chk("mid-rst tx_data", {8'd0, tx_data}, 16'd0);
        rst = 0;
        @(negedge clk);
        tx_done = 1;
        @(negedge clk); tx_done = 0;
        repeat (2) @(negedge clk);
        chk("post-rst no trmt", 16'(n_trmt - t0), 16'd0);
        chk("post-rst no resp_sent", 16'(n_rs - r0), 16'd0);
        chk("post-rst cmd_rdy", {15'd0, cmd_rdy}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_link.md
# cmd_link

Byte-to-command bridge between the UART byte transceiver and `dig_core`; it is the link-side end of the `cmd`/`cmd_rdy`/`clr_cmd_rdy` and `resp`/`send_resp`/`resp_sent` handshakes. It assembles two received UART bytes into one 16-bit command, presents it to `dig_core`, and holds the UART byte stream off until `dig_core` clears the command. On the return path it accepts 8-bit responses from `dig_core`, queues at most one behind the byte in flight, drives the UART transmitter, and reports completion.

## Interface
- `TIMEOUT`, default 50000: clocks allowed between the high and low bytes of a command before the partial command is discarded. Minimum 2.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_rdy` in 1: UART receiver holds a byte. Level signal.
- `rx_data` in 8: received byte, valid while `rx_rdy`=1.
- `clr_rx_rdy` out 1: combinational pulse, high in the cycle a byte is consumed.
- `cmd` out 16: assembled command. `[15:8]` is the first byte, `[7:0]` the second.
- `cmd_rdy` out 1: registered. `cmd` is valid and stable while this is high.
- `clr_cmd_rdy` in 1: `dig_core` consumed `cmd`.
- `resp` in 8: response byte, sampled when `send_resp`=1.
- `send_resp` in 1: one-cycle request to send `resp`.
- `resp_sent` out 1: registered one-cycle pulse; one response byte finished.
- `tx_data` out 8: byte to the UART transmitter. Stable from `trmt` until `tx_done`.
- `trmt` out 1: registered one-cycle start pulse to the transmitter.
- `tx_done` in 1: one-cycle pulse; the transmitter finished its byte.
- `to_err` out 1: registered one-cycle pulse when an inter-byte timeout occurs.
- `resp_ovr` out 1: sticky flag; a response was dropped. Cleared only by `rst`.

## Operation
- Receive FSM has three states: RX_IDLE, RX_HIGH, RX_FULL.
- RX_IDLE:
  - If `rx_rdy`=1: capture `rx_data` into `cmd[15:8]`, assert `clr_rx_rdy`, clear the timer to 0, go to RX_HIGH.
- RX_HIGH:
  - If `rx_rdy`=1: capture `rx_data` into `cmd[7:0]`, assert `clr_rx_rdy`, set `cmd_rdy`, go to RX_FULL.
  - Else, if the timer equals `TIMEOUT-1`: pulse `to_err`, go to RX_IDLE. `cmd` is left unchanged.
  - Else: increment the timer.
  - If `rx_rdy` arrives in the same cycle the timer reaches `TIMEOUT-1`, the byte wins and no timeout occurs.
- RX_FULL:
  - `cmd_rdy`=1 and `cmd` is frozen.
  - `rx_rdy` is ignored. The byte stays pending in the UART and `clr_rx_rdy` stays 0.
  - `clr_cmd_rdy`=1: clear `cmd_rdy`, go to RX_IDLE. A pending byte is consumed on the next cycle.
- `clr_cmd_rdy` in any state other than RX_FULL is ignored.
- Timer width is `$clog2(TIMEOUT)` bits. The timer saturates and never wraps.
- Transmit path has two states, TX_IDLE and TX_BUSY, plus a one-deep pending register (`pend_vld`, `pend_byte`).
- TX_IDLE:
  - `send_resp`=1: latch `resp` into `tx_data`, pulse `trmt` next cycle, go to TX_BUSY.
- TX_BUSY:
  - `send_resp`=1 and `pend_vld`=0: store `resp` in `pend_byte`, set `pend_vld`.
  - `send_resp`=1 and `pend_vld`=1: drop the byte, set `resp_ovr`.
  - `tx_done`=1: pulse `resp_sent` next cycle.
    - If `pend_vld`=1: load `pend_byte` into `tx_data`, clear `pend_vld`, pulse `trmt` next cycle, stay in TX_BUSY.
    - Else: go to TX_IDLE.
  - `tx_done` and `send_resp` in the same cycle with `pend_vld`=0: the new byte goes straight into `tx_data` (`trmt` next cycle). It does not enter the pending register.
- `tx_done` in TX_IDLE is ignored.
- The receive and transmit paths are independent and may be active in the same cycle.

## Timing
- Reset values:
  - Outputs: `cmd`=16'h0000, `cmd_rdy`=0, `clr_rx_rdy`=0, `tx_data`=8'h00, `trmt`=0, `resp_sent`=0, `to_err`=0, `resp_ovr`=0.
  - Internal: `pend_vld`=0, timer=0, both FSMs idle.
- `rst` mid-operation discards any partial or pending command or response. No `resp_sent` is issued for an in-flight byte.
- `clr_rx_rdy` is high in the same cycle that `rx_rdy` is sampled. The UART drops `rx_rdy` on the following edge.
- `cmd_rdy` rises on the edge that captures the second byte.
- `cmd_rdy` falls on the edge that samples `clr_cmd_rdy`=1.
- `send_resp` at edge N gives `trmt`=1 during cycle N+1.
- `tx_done` at edge M gives `resp_sent`=1 during cycle M+1. A pending byte also gives `trmt`=1 during cycle M+1.
- Timeout: with no second byte, `to_err` pulses `TIMEOUT` cycles after the first-byte capture edge.

## Test plan
- Bytes 8'hA5 then 8'h3C with a 10-cycle gap -> `cmd`=16'hA53C, `cmd_rdy`=1, two `clr_rx_rdy` pulses, `to_err`=0.
- With `cmd_rdy` held, offer byte 8'h11, then pulse `clr_cmd_rdy` after 20 cycles -> `cmd` stays 16'hA53C, no `clr_rx_rdy` while held, 8'h11 consumed the cycle after the clear.
- `TIMEOUT`=8, single byte 8'h7E, then silence -> `to_err` pulse exactly 8 cycles after capture. Next bytes 8'h01, 8'h02 -> `cmd`=16'h0102.
- `send_resp` with `resp`=8'hA5 -> `trmt` one cycle later with `tx_data`=8'hA5. `tx_done` -> `resp_sent` one cycle later.
- Three `send_resp` (8'h01, 8'h02, 8'h03) while busy on 8'h00 -> 8'h01 transmitted after the first `tx_done`, 8'h02 and 8'h03 dropped, `resp_ovr`=1, exactly two `resp_sent` pulses.
- Assert `rst` in RX_HIGH and in TX_BUSY with a byte pending -> all outputs return to reset values next cycle, and no `trmt` for the pending byte.
